// File: rtl/wb_bridge_pkg.sv
// Shared opcodes, response codes and FSM states for the WB command bridge.
package wb_bridge_pkg;

  localparam int OP_W  = 2;
  localparam int RSP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SETADDR = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_SETSEL  = 2'b11
  } op_e;

  typedef enum logic [RSP_W-1:0] {
    RSP_OK  = 2'b00,
    RSP_RD  = 2'b01,
    RSP_WR  = 2'b10,
    RSP_ERR = 2'b11
  } rsp_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    ABORT = 2'd2
  } state_e;

endpackage

// File: rtl/wb_bridge_txn_fifo.sv
// In-flight transaction FIFO ({we,addr}) with same-cycle push/pop and flush.
module wb_bridge_txn_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign pop     = pop_i && !empty_o;
  assign push    = push_i && (!full_o || pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/wb_pipelined_cmd_bridge.sv
// Host command to pipelined Wishbone master bridge, DEPTH outstanding.
// Optional ack watchdog: define WB_BRIDGE_TIMEOUT_EN.
module wb_pipelined_cmd_bridge
  import wb_bridge_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 4,
  parameter int TMO   = 255,
  localparam int SW   = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_stb,
  input  logic [DW+1:0] cmd_word,
  output logic          cmd_busy,
  output logic          rsp_stb,
  output logic [DW+1:0] rsp_word,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data_output,
  output logic [SW-1:0] wb_sel,
  input  logic          wb_ack,
  input  logic          wb_stall,
  input  logic          wb_err,
  input  logic [DW-1:0] wb_data
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          inc_q, inc_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [SW-1:0] wsel_q, wsel_d;
  logic          rsp_stb_q, rsp_stb_d;
  logic [DW+1:0] rsp_word_q, rsp_word_d;

  op_e           op;
  logic [DW-1:0] pl;
  logic          is_bus, in_bus, issue, abort, tmo_hit;
  logic          ack_ok, acc, push, pop;
  logic [AW:0]   f_dout;
  logic          f_full, f_empty;
  logic [CW-1:0] f_cnt, cnt_nx;
  logic [AW-1:0] oldest;
  logic [DW-1:0] ab_data;

  assign op     = op_e'(cmd_word[DW+1:DW]);
  assign pl     = cmd_word[DW-1:0];
  assign is_bus = (op == OP_WRITE) || (op == OP_READ);
  assign in_bus = (state_q == BUS);
  assign issue  = stb_q && !wb_stall;
  assign abort  = in_bus && (wb_err || tmo_hit);
  assign ack_ok = in_bus && wb_ack && !f_empty && !abort;
  assign push   = issue && !abort;
  assign pop    = ack_ok;
  assign cnt_nx = f_cnt + CW'(push) - CW'(pop);
  assign oldest = f_empty ? waddr_q : f_dout[AW-1:0];

  // Pending strobe counts toward DEPTH; cfg ops wait out an ack response.
  assign cmd_busy = (state_q == ABORT)
                  || (stb_q && wb_stall)
                  || f_full
                  || (stb_q && f_cnt == CW'(DEPTH - 1))
                  || abort
                  || (!is_bus && ack_ok);
  assign acc = cmd_stb && !cmd_busy;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_run;

  assign tmo_run = in_bus && (f_cnt != '0) && !issue && !wb_ack;
  assign tmo_hit = tmo_run && (tmo_q == TW'(TMO - 1));

  always_comb begin
    tmo_d = '0;
    if (tmo_run) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  wb_bridge_txn_fifo #(
    .W     (AW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   ({we_q, waddr_q}),
    .pop_i   (pop),
    .flush_i (abort),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_cnt)
  );

  always_comb begin
    ab_data = DW'(oldest);
    if (tmo_hit) ab_data[DW-1] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    inc_d      = inc_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    we_d       = we_q;
    waddr_d    = waddr_q;
    wdat_d     = wdat_q;
    wsel_d     = wsel_q;
    rsp_stb_d  = 1'b0;
    rsp_word_d = rsp_word_q;

    if (issue) stb_d = 1'b0;

    if (acc) begin
      unique case (op)
        OP_SETADDR: begin
          addr_d     = pl[AW-1:0];
          inc_d      = pl[AW];
          rsp_stb_d  = 1'b1;
          rsp_word_d = {RSP_OK, DW'(pl[AW-1:0])};
        end
        OP_SETSEL: begin
          sel_d      = pl[SW-1:0];
          rsp_stb_d  = 1'b1;
          rsp_word_d = {RSP_OK, DW'(pl[SW-1:0])};
        end
        OP_WRITE, OP_READ: begin
          stb_d   = 1'b1;
          we_d    = (op == OP_WRITE);
          waddr_d = addr_q;
          wdat_d  = pl;
          wsel_d  = sel_q;
          if (inc_q) addr_d = addr_q + 1'b1;
        end
      endcase
    end

    if (ack_ok) begin
      rsp_stb_d  = 1'b1;
      rsp_word_d = f_dout[AW] ? {RSP_WR, DW'(f_dout[AW-1:0])}
                              : {RSP_RD, wb_data};
    end

    unique case (state_q)
      IDLE: if (acc && is_bus) state_d = BUS;
      BUS: begin
        if (abort) begin
          state_d    = ABORT;
          stb_d      = 1'b0;
          rsp_stb_d  = 1'b1;
          rsp_word_d = {RSP_ERR, ab_data};
        end else if (cnt_nx == '0 && !stb_d) begin
          state_d = IDLE;
        end
      end
      ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cyc_d = (state_d == BUS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inc_q      <= 1'b0;
      sel_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdat_q     <= '0;
      wsel_q     <= '0;
      rsp_stb_q  <= 1'b0;
      rsp_word_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inc_q      <= inc_d;
      sel_q      <= sel_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdat_q     <= wdat_d;
      wsel_q     <= wsel_d;
      rsp_stb_q  <= rsp_stb_d;
      rsp_word_q <= rsp_word_d;
    end
  end

  assign wb_cyc         = cyc_q;
  assign wb_stb         = stb_q;
  assign wb_we          = we_q;
  assign wb_addr        = waddr_q;
  assign wb_data_output = wdat_q;
  assign wb_sel         = wsel_q;
  assign rsp_stb        = rsp_stb_q;
  assign rsp_word       = rsp_word_q;

endmodule
